// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4 master for the MEM stage: each load/store becomes one
// single-beat burst, with byte-lane shifting so MEM only ever sees LSB-justified data.
module lsu_axi_master #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [63:0] rd_addr,
    input  logic [1:0]  rd_size,
    output logic [63:0] rd_data,
    output logic        rd_finish,
    input  logic        wr_req,
    input  logic [63:0] wr_addr,
    input  logic [1:0]  wr_size,
    input  logic [63:0] wr_data,
    output logic        wr_finish,
    output logic        bus_err,
    output logic [3:0]  arid,
    output logic [63:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [63:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;

    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign awid    = AXI_ID;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;

    function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] s);
        logic m;
        case (s)
            2'd0:    m = 1'b0;
            2'd1:    m = a[0];
            2'd2:    m = |a[1:0];
            default: m = |a[2:0];
        endcase
        return m;
    endfunction

    function automatic logic [7:0] lane_strobe(input logic [2:0] a, input logic [1:0] s);
        logic [15:0] m;
        case (s)
            2'd0:    m = 16'h0001;
            2'd1:    m = 16'h0003;
            2'd2:    m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        m = m << a;
        return m[7:0];
    endfunction

    // Finish pulses are set on the edge entering DONE so they line up with the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rd_data   <= '0;
            rd_finish <= 1'b0;
            wr_finish <= 1'b0;
            bus_err   <= 1'b0;
            araddr    <= '0;
            arsize    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            awsize    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            rd_finish <= 1'b0;
            wr_finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        araddr <= rd_addr;
                        arsize <= {1'b0, rd_size};
                        if (is_misaligned(rd_addr[2:0], rd_size)) begin
                            rd_data   <= '0;
                            bus_err   <= 1'b1;
                            rd_finish <= 1'b1;
                            state     <= DONE;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= AR;
                        end
                    end else if (wr_req) begin
                        awaddr  <= wr_addr;
                        awsize  <= {1'b0, wr_size};
                        wdata   <= wr_data << {wr_addr[2:0], 3'b000};
                        wstrb   <= lane_strobe(wr_addr[2:0], wr_size);
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (is_misaligned(wr_addr[2:0], wr_size)) begin
                            bus_err   <= 1'b1;
                            wr_finish <= 1'b1;
                            state     <= DONE;
                        end else begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= AW_W;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rd_data   <= rdata >> {araddr[2:0], 3'b000};
                        bus_err   <= (rresp != 2'b00) || !rlast;
                        rd_finish <= 1'b1;
                        state     <= DONE;
                    end
                end
                AW_W: begin
                    // AW and W complete independently; move on once both have handshaken.
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        bus_err   <= (bresp != 2'b00);
                        wr_finish <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: a small AXI slave responder inside the stimulus
// task, with hand-computed expectations for each transaction.
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [63:0] rd_addr;
    logic [1:0]  rd_size;
    logic [63:0] rd_data;
    logic        rd_finish;
    logic        wr_req;
    logic [63:0] wr_addr;
    logic [1:0]  wr_size;
    logic [63:0] wr_data;
    logic        wr_finish;
    logic        bus_err;
    logic [3:0]  arid;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [63:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    lsu_axi_master #(.AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_data(rd_data), .rd_finish(rd_finish),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data), .wr_finish(wr_finish),
        .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int errors = 0;

    int          first_ar, first_aw, ar_cycles, aw_cycles, w_cycles;
    int          rd_fin_cnt, wr_fin_cnt, rd_fin_cycle, wr_fin_cycle;
    logic [63:0] seen_araddr, seen_awaddr, seen_wdata, rd_val;
    logic [2:0]  seen_arsize, seen_awsize;
    logic [7:0]  seen_wstrb;
    logic        rd_err, wr_err, aw_unstable, w_dropped;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one request (or both) and plays an AXI slave until every finish has been seen.
    task automatic applyStimulus(input logic do_rd, input logic do_wr, input logic [63:0] addr,
                                 input logic [1:0] size, input logic [63:0] data,
                                 input logic [1:0] resp, input int aw_delay);
        int cyc     = 0;
        int aw_wait = 0;
        int settle  = 0;
        first_ar = -1; first_aw = -1; ar_cycles = 0; aw_cycles = 0; w_cycles = 0;
        rd_fin_cnt = 0; wr_fin_cnt = 0; rd_fin_cycle = -1; wr_fin_cycle = -1;
        seen_araddr = '0; seen_awaddr = '0; seen_wdata = '0; rd_val = '0;
        seen_arsize = '0; seen_awsize = '0; seen_wstrb = '0;
        rd_err = 1'b0; wr_err = 1'b0; aw_unstable = 1'b0; w_dropped = 1'b0;
        rd_req = do_rd; wr_req = do_wr;
        rd_addr = addr; rd_size = size; wr_addr = addr; wr_size = size; wr_data = data;
        rdata = data; rresp = resp; bresp = resp; rlast = 1'b1;
        arready = 1'b1; wready = 1'b1; awready = (aw_delay == 0);
        rvalid = 1'b0; bvalid = 1'b0;
        while (settle < 2 && cyc < 60) begin
            stepCycle();
            cyc++;
            if (arvalid) begin
                ar_cycles++;
                if (first_ar < 0) begin
                    first_ar = cyc; seen_araddr = araddr; seen_arsize = arsize;
                end
            end
            if (awvalid) begin
                aw_cycles++;
                if (first_aw < 0) begin
                    first_aw = cyc; seen_awaddr = awaddr; seen_awsize = awsize;
                end else if (awaddr !== seen_awaddr) begin
                    aw_unstable = 1'b1;
                end
                if (!wvalid) w_dropped = 1'b1;
            end
            if (wvalid) begin
                w_cycles++; seen_wdata = wdata; seen_wstrb = wstrb;
            end
            if (rd_finish) begin
                rd_fin_cnt++;
                if (rd_fin_cnt == 1) begin
                    rd_fin_cycle = cyc; rd_err = bus_err; rd_val = rd_data;
                end
                rd_req = 1'b0;
            end
            if (wr_finish) begin
                wr_fin_cnt++;
                if (wr_fin_cnt == 1) begin
                    wr_fin_cycle = cyc; wr_err = bus_err;
                end
                wr_req = 1'b0;
            end
            rvalid = rready;
            bvalid = bready;
            if (awvalid && !awready) aw_wait++;
            awready = (aw_wait >= aw_delay);
            if ((!do_rd || rd_fin_cnt > 0) && (!do_wr || wr_fin_cnt > 0)) settle++;
        end
        checkOutput("done_in_budget", 64'(settle >= 2), 64'd1);
        rd_req = 1'b0; wr_req = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int fin;
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; rd_size = '0; wr_addr = '0; wr_size = '0; wr_data = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        repeat (2) stepCycle();

        checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
        checkOutput("rst_valids", 64'({awvalid, wvalid, rready, bready}), 64'd0);
        checkOutput("rst_finish", 64'({rd_finish, wr_finish, bus_err}), 64'd0);
        checkOutput("rst_rd_data", rd_data, 64'd0);
        checkOutput("rst_araddr", araddr, 64'd0);
        checkOutput("rst_wdata", wdata, 64'd0);
        checkOutput("rst_wstrb", 64'(wstrb), 64'd0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] aligned 8-byte load");
        applyStimulus(1'b1, 1'b0, 64'h8000_0010, 2'd3, 64'h1122_3344_5566_7788, 2'd0, 0);
        checkOutput("ld8_araddr", seen_araddr, 64'h8000_0010);
        checkOutput("ld8_arsize", 64'(seen_arsize), 64'd3);
        checkOutput("ld8_ar_cycle", 64'(first_ar), 64'd1);
        checkOutput("ld8_fin_cycle", 64'(rd_fin_cycle), 64'd3);
        checkOutput("ld8_fin_count", 64'(rd_fin_cnt), 64'd1);
        checkOutput("ld8_data", rd_val, 64'h1122_3344_5566_7788);
        checkOutput("ld8_err", 64'(rd_err), 64'd0);
        checkOutput("ld8_hold", rd_data, 64'h1122_3344_5566_7788);

        $display("[TB] byte load at offset 5");
        applyStimulus(1'b1, 1'b0, 64'h8000_0005, 2'd0, 64'hAABB_CCDD_EEFF_0011, 2'd0, 0);
        checkOutput("ldb_araddr", seen_araddr, 64'h8000_0005);
        checkOutput("ldb_arsize", 64'(seen_arsize), 64'd0);
        checkOutput("ldb_low_byte", 64'(rd_val[7:0]), 64'hCC);
        checkOutput("ldb_data", rd_val, 64'h0000_0000_00AA_BBCC);

        $display("[TB] halfword store at offset 6");
        applyStimulus(1'b0, 1'b1, 64'h8000_0006, 2'd1, 64'h1234, 2'd0, 0);
        checkOutput("sth_awaddr", seen_awaddr, 64'h8000_0006);
        checkOutput("sth_awsize", 64'(seen_awsize), 64'd1);
        checkOutput("sth_wstrb", 64'(seen_wstrb), 64'hC0);
        checkOutput("sth_wdata", seen_wdata, 64'h1234_0000_0000_0000);
        checkOutput("sth_fin_cycle", 64'(wr_fin_cycle), 64'd3);
        checkOutput("sth_err", 64'(wr_err), 64'd0);
        checkOutput("sth_no_ar", 64'(ar_cycles), 64'd0);

        $display("[TB] store with delayed awready");
        applyStimulus(1'b0, 1'b1, 64'h8000_0008, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 2'd0, 4);
        checkOutput("std_w_cycles", 64'(w_cycles), 64'd1);
        checkOutput("std_w_dropped", 64'(w_dropped), 64'd1);
        checkOutput("std_aw_cycles", 64'(aw_cycles), 64'd4);
        checkOutput("std_aw_stable", 64'(aw_unstable), 64'd0);
        checkOutput("std_awaddr", seen_awaddr, 64'h8000_0008);
        checkOutput("std_wstrb", 64'(seen_wstrb), 64'hFF);
        checkOutput("std_wdata", seen_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        checkOutput("std_fin_count", 64'(wr_fin_cnt), 64'd1);
        checkOutput("std_fin_cycle", 64'(wr_fin_cycle), 64'd6);

        $display("[TB] misaligned word load");
        applyStimulus(1'b1, 1'b0, 64'h8000_0002, 2'd2, 64'h5555_6666_7777_8888, 2'd0, 0);
        checkOutput("mis_no_ar", 64'(ar_cycles), 64'd0);
        checkOutput("mis_fin_cycle", 64'(rd_fin_cycle), 64'd1);
        checkOutput("mis_err", 64'(rd_err), 64'd1);
        checkOutput("mis_data", rd_val, 64'd0);

        $display("[TB] load with SLVERR");
        applyStimulus(1'b1, 1'b0, 64'h8000_0020, 2'd3, 64'h0123_4567_89AB_CDEF, 2'd2, 0);
        checkOutput("slv_err", 64'(rd_err), 64'd1);
        checkOutput("slv_fin_cycle", 64'(rd_fin_cycle), 64'd3);

        $display("[TB] simultaneous load and store");
        applyStimulus(1'b1, 1'b1, 64'h8000_0040, 2'd3, 64'h0F0E_0D0C_0B0A_0908, 2'd0, 0);
        checkOutput("both_ar_first", 64'(first_ar), 64'd1);
        checkOutput("both_rd_fin", 64'(rd_fin_cycle), 64'd3);
        checkOutput("both_aw_after", 64'(first_aw), 64'd5);
        checkOutput("both_wr_fin", 64'(wr_fin_cycle), 64'd7);
        checkOutput("both_rd_data", rd_val, 64'h0F0E_0D0C_0B0A_0908);

        $display("[TB] reset during R");
        rd_req = 1'b1; rd_addr = 64'h8000_0030; rd_size = 2'd3;
        arready = 1'b1; rvalid = 1'b0; rdata = 64'hFFFF_0000_FFFF_0000; rresp = 2'd0;
        stepCycle();
        checkOutput("rstr_arvalid_pre", 64'(arvalid), 64'd1);
        stepCycle();
        checkOutput("rstr_rready_pre", 64'(rready), 64'd1);
        rst = 1'b1; rd_req = 1'b0;
        stepCycle();
        checkOutput("rstr_valids", 64'({arvalid, awvalid, wvalid}), 64'd0);
        checkOutput("rstr_readies", 64'({rready, bready}), 64'd0);
        checkOutput("rstr_finish", 64'({rd_finish, wr_finish}), 64'd0);
        rst = 1'b0;
        fin = 0;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            if (rd_finish || wr_finish) fin++;
        end
        checkOutput("rstr_no_finish", 64'(fin), 64'd0);

        applyStimulus(1'b1, 1'b0, 64'h8000_0018, 2'd2, 64'h0000_0000_89AB_CDEF, 2'd0, 0);
        checkOutput("recover_fin_cycle", 64'(rd_fin_cycle), 64'd3);
        checkOutput("recover_data", rd_val, 64'h0000_0000_89AB_CDEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
# lsu_axi_master

Single-outstanding AXI4 master that serves the MEM stage's load/store request/finish handshake. Sits directly downstream of MEM, between it and the data-side AXI4 interconnect. Converts each load or store into one single-beat AXI4 burst. Handles byte-lane alignment (shift and strobe) so MEM always sees and supplies LSB-justified data. Returns a one-cycle finish pulse.

## Interface
- `AXI_ID`, default 0: constant driven on `arid`/`awid` (4 bits).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rd_req` in 1: load request. Level; held by MEM until `rd_finish`.
- `rd_addr` in 64: load byte address.
- `rd_size` in 2: access size, 0/1/2/3 = 1/2/4/8 bytes.
- `rd_data` out 64: load data, LSB-justified (byte at `rd_addr` in [7:0]).
- `rd_finish` out 1: one-cycle pulse, load done.
- `wr_req` in 1: store request. Level; held by MEM until `wr_finish`.
- `wr_addr` in 64: store byte address.
- `wr_size` in 2: store size, same encoding as `rd_size`.
- `wr_data` in 64: store data, LSB-justified.
- `wr_finish` out 1: one-cycle pulse, store done.
- `bus_err` out 1: valid with either finish pulse. Set on non-OKAY response or misalignment.
- AR channel: `arid` out 4, `araddr` out 64, `arlen` out 8 (=0), `arsize` out 3, `arburst` out 2 (=INCR), `arvalid` out 1, `arready` in 1.
- R channel: `rdata` in 64, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- AW channel: `awid` out 4, `awaddr` out 64, `awlen` out 8 (=0), `awsize` out 3, `awburst` out 2 (=INCR), `awvalid` out 1, `awready` in 1.
- W channel: `wdata` out 64, `wstrb` out 8, `wlast` out 1 (=1), `wvalid` out 1, `wready` in 1.
- B channel: `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE:
  - `rd_req` → latch addr/size, go to AR.
  - Else `wr_req` → latch addr/size/data, go to AW_W.
  - Both requests high → the load wins. The store is taken after the load's DONE.
- Misalignment: `addr % (1<<size) != 0`. A misaligned request issues no AXI traffic. The FSM goes straight to DONE with `bus_err`=1 and `rd_data`=0.
- AR:
  - `arvalid`=1; `araddr` = latched address, unmodified; `arsize` = size.
  - On `arready` → R.
- R:
  - `rready`=1. On `rvalid`, capture `rdata >> (8*addr[2:0])` into the data register.
  - `bus_err` = (`rresp`!=0). `rlast`=0 is also treated as an error.
  - Go to DONE.
- AW_W:
  - `awvalid` and `wvalid` are raised together. Each drops independently once its own handshake completes; a per-channel done flag tracks this.
  - Both flags set → B.
  - `wdata` = `wr_data << (8*addr[2:0])`.
  - `wstrb` = ((1<<(1<<size))-1) << addr[2:0].
- B:
  - `bready`=1. On `bvalid`, `bus_err` = (`bresp`!=0). Go to DONE.
- DONE:
  - Pulse `rd_finish` or `wr_finish` (matching the operation) for exactly one cycle, then return to IDLE.
  - Requests are ignored in DONE. MEM drops its req on the same edge, so no request is re-accepted twice.
- `rd_data` and `bus_err` hold their value from DONE until the next DONE.
- Address, size and data are latched at acceptance. Input changes after that have no effect.

## Timing
- Reset values:
  - State IDLE.
  - All `*valid`, `*ready`, `rd_finish`, `wr_finish` and `bus_err` = 0.
  - `rd_data` = 0.
  - `araddr`/`awaddr`/`wdata`/`wstrb` = 0.
- Reset mid-transaction drops all valids on the next edge and returns the FSM to IDLE. This is permitted only with a system-wide reset.
- All outputs are registered or decoded from state only. There is no combinational path from AXI inputs to AXI outputs.
- Minimum load latency, with `arready` and `rvalid` both immediate: req sampled at edge 0, then AR cycle 1, R cycle 2, `rd_finish` high in cycle 3. That is 3 cycles from the accept edge.
- Minimum store latency is also 3 cycles: AW_W, B, DONE.
- `valid` held stable with its payload until `ready`, per AXI4. `ready` may be high before `valid`.
- Back-to-back: after DONE, one IDLE cycle precedes the next acceptance.

## Test plan
- Aligned 8-byte load @0x8000_0010. `arready`=1, `rdata`=0x1122334455667788, `rresp`=0. Expect `arsize`=3, `rd_data`=0x1122334455667788, `rd_finish` one cycle at cycle 3, `bus_err`=0.
- Byte load @0x8000_0005, `rdata`=0xAABBCCDDEEFF0011. Expect `rd_data`[7:0]=0xCC and `rd_data`=0xAABBCC.
- 2-byte store @0x8000_0006, `wr_data`=0x1234. Expect `wstrb`=0xC0, `wdata`[63:48]=0x1234, `wr_finish` after `bvalid`.
- Store with `awready` delayed 4 cycles and `wready` immediate. Expect `wvalid` low after its handshake, `awvalid` held with a stable `awaddr`, and exactly one `wr_finish`.
- 4-byte load @0x8000_0002 (misaligned). Expect no `arvalid`, `rd_finish` with `bus_err`=1. A load with `rresp`=2 (SLVERR) also gives `bus_err`=1.
- `rd_req` and `wr_req` raised together. Expect the AR burst first, then AW/W. Assert `rst` during R: all valids are 0 on the next cycle, no finish pulse.
